// File: rtl/seq_priority_encoder.sv
// Serialises an N-bit request bitmap into the binary indices of its set bits,
// one index per output handshake, lowest-first or highest-first.
//
// state | meaning
// IDLE  | waiting for a request vector, in_ready high
// SCAN  | draining pending bits, one index per out handshake
module seq_priority_encoder #(
    parameter int N         = 10,
    parameter int W         = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_vec,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic         zero_drop,
    output logic         busy
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]   state;
    logic [N-1:0] pending;
    logic [N-1:0] sel_oh;
    logic [W-1:0] sel_idx;
    logic         single;
    logic         zero_drop_q;

    // Priority scan: LSB mode keeps the first hit, MSB mode keeps the last.
    always_comb begin
        sel_idx = '0;
        sel_oh  = '0;
        for (int i = 0; i < N; i++) begin
            if (pending[i] && (MSB_FIRST || sel_oh == '0)) begin
                sel_idx   = W'(i);
                sel_oh    = '0;
                sel_oh[i] = 1'b1;
            end
        end
    end

    assign single = (pending != '0) && ((pending & (pending - N'(1))) == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= '0;
            zero_drop_q <= 1'b0;
        end else begin
            zero_drop_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (in_vec != '0) begin
                            pending <= in_vec;
                            state   <= SCAN;
                        end else begin
                            zero_drop_q <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (out_ready) begin
                        pending <= pending & ~sel_oh;
                        if (single) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    pending <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SCAN);
    assign busy      = (state == SCAN);
    assign out_idx   = sel_idx;
    assign out_last  = (state == SCAN) && single;
    assign zero_drop = zero_drop_q;

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Bench: drives an LSB-first and an MSB-first encoder with the same stimulus
// and compares both against per-vector index queues.
module tb_seq_priority_encoder;

    localparam int N = 10;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] in_vec;
    logic         out_ready;

    logic         l_in_ready, l_out_valid, l_out_last, l_zero_drop, l_busy;
    logic [W-1:0] l_out_idx;
    logic         m_in_ready, m_out_valid, m_out_last, m_zero_drop, m_busy;
    logic [W-1:0] m_out_idx;

    int total = 0;
    int bad   = 0;

    int q_lsb[$];
    int q_msb[$];
    bit exp_zd;

    always #5 clk = ~clk;

    seq_priority_encoder #(.N(N), .W(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
        .in_vec(in_vec), .out_valid(l_out_valid), .out_ready(out_ready),
        .out_idx(l_out_idx), .out_last(l_out_last), .zero_drop(l_zero_drop),
        .busy(l_busy)
    );

    seq_priority_encoder #(.N(N), .W(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(m_in_ready),
        .in_vec(in_vec), .out_valid(m_out_valid), .out_ready(out_ready),
        .out_idx(m_out_idx), .out_last(m_out_last), .zero_drop(m_zero_drop),
        .busy(m_busy)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs, check outputs against the model, advance model.
    task automatic cycle(input bit rst, input bit v, input logic [N-1:0] vec, input bit rdy);
        bit idle;
        rst_n     = ~rst;
        in_valid  = v;
        in_vec    = vec;
        out_ready = rdy;
        #1;
        idle = (q_lsb.size() == 0);
        chk("l_in_ready", int'(l_in_ready), int'(idle));
        chk("m_in_ready", int'(m_in_ready), int'(idle));
        chk("l_out_valid", int'(l_out_valid), int'(!idle));
        chk("m_out_valid", int'(m_out_valid), int'(!idle));
        chk("l_busy", int'(l_busy), int'(!idle));
        chk("m_busy", int'(m_busy), int'(!idle));
        chk("l_zero_drop", int'(l_zero_drop), int'(exp_zd));
        chk("m_zero_drop", int'(m_zero_drop), int'(exp_zd));
        if (idle) begin
            chk("l_idx_idle", int'(l_out_idx), 0);
            chk("m_idx_idle", int'(m_out_idx), 0);
            chk("l_last_idle", int'(l_out_last), 0);
            chk("m_last_idle", int'(m_out_last), 0);
        end else begin
            chk("l_out_idx", int'(l_out_idx), q_lsb[0]);
            chk("m_out_idx", int'(m_out_idx), q_msb[0]);
            chk("l_out_last", int'(l_out_last), int'(q_lsb.size() == 1));
            chk("m_out_last", int'(m_out_last), int'(q_msb.size() == 1));
        end
        if (rst) begin
            q_lsb.delete();
            q_msb.delete();
            exp_zd = 1'b0;
        end else begin
            exp_zd = idle && v && (vec == '0);
            if (idle && v) begin
                for (int i = 0; i < N; i++) begin
                    if (vec[i]) begin
                        q_lsb.push_back(i);
                        q_msb.push_front(i);
                    end
                end
            end else if (!idle && rdy) begin
                void'(q_lsb.pop_front());
                void'(q_msb.pop_front());
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, $urandom, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        @(negedge clk);
        cycle(1'b1, 1'b1, 10'h3ff, 1'b1);
        idle_cycles(1);

        // single one-hot
        cycle(1'b0, 1'b1, 10'b0000000001, 1'b1);
        idle_cycles(3);

        // multi-bit, full throughput
        cycle(1'b0, 1'b1, 10'b1000100101, 1'b1);
        idle_cycles(6);

        // backpressure pattern, in_vec scrambled while busy
        cycle(1'b0, 1'b1, 10'b1000100101, 1'b0);
        begin
            bit pat[12] = '{0, 1, 0, 0, 1, 0, 1, 1, 0, 1, 1, 1};
            for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, $urandom, pat[i]);
        end
        idle_cycles(2);

        // all ones
        cycle(1'b0, 1'b1, 10'b1111111111, 1'b1);
        idle_cycles(12);

        // zero vector, twice back to back
        cycle(1'b0, 1'b1, 10'b0, 1'b1);
        cycle(1'b0, 1'b1, 10'b0, 1'b1);
        idle_cycles(2);

        // reset mid-burst, then a fresh one-hot
        cycle(1'b0, 1'b1, 10'b0000011110, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        cycle(1'b1, 1'b0, '0, 1'b1);
        cycle(1'b0, 1'b1, 10'b0100000000, 1'b1);
        idle_cycles(3);

        // randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            logic [N-1:0] vec;
            vec = ($urandom_range(0, 5) == 0) ? '0 : N'($urandom);
            cycle($urandom_range(0, 60) == 0, $urandom_range(0, 2) != 0, vec,
                  $urandom_range(0, 3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_priority_encoder.md
Name: seq_priority_encoder

Overview:
Parametrised, sequential successor to the one-hot 10-to-4 encoder. It accepts an N-bit request vector through a valid/ready handshake and emits the binary index of every set bit, one index per handshake, in priority order. Any number of bits may be set. It sits between request-bitmap producers (interrupt and status collectors) and index consumers (dispatch logic, FIFOs).

Parameters:
N, 10, width of the request vector (N >= 2)
W, 4, index width; must satisfy W >= clog2(N)
MSB_FIRST, 0, 0 = lowest set bit emitted first; 1 = highest set bit emitted first

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_vec is valid
in_ready  output  1  block can accept a vector
in_vec  input  N  request bitmap
out_valid  output  1  out_idx is valid
out_ready  input  1  consumer accepts out_idx
out_idx  output  W  binary index of the current highest-priority pending bit
out_last  output  1  out_idx is the final index of this vector
zero_drop  output  1  one-cycle pulse: an all-zero vector was accepted and discarded
busy  output  1  a vector is being serialised

Behaviour:
- One clock domain (clk). Reset is synchronous and active-low (rst_n).
- Reset, sampled at a clk edge with rst_n=0:
  - state=IDLE, pending=0
  - in_ready=1 from the first cycle after reset
  - out_valid=0, out_idx=0, out_last=0, zero_drop=0, busy=0
- Reset wins over every other event. A reset in mid-burst discards all remaining indices; no partial output follows.
- State machine, two states:
  - IDLE:
    - in_ready=1, out_valid=0, busy=0.
    - On in_valid&&in_ready with in_vec!=0: pending<=in_vec, go to SCAN.
    - On in_valid&&in_ready with in_vec==0: stay in IDLE, zero_drop=1 for exactly the next cycle.
  - SCAN:
    - in_ready=0, busy=1, out_valid=1.
    - out_idx = index of lowest set bit of pending (MSB_FIRST=0) or highest set bit (MSB_FIRST=1).
    - out_last = 1 when exactly one bit of pending is set.
    - On out_valid&&out_ready: clear the selected bit in pending.
    - If out_last was 1 at that handshake, go to IDLE.
- Latency:
  - First index is valid one cycle after the input handshake.
  - With out_ready held at 1, k set bits drain in exactly k cycles.
  - in_ready returns one cycle after the last output handshake (one bubble cycle between vectors; no same-cycle reload).
- Backpressure:
  - While out_valid=1 and out_ready=0, out_idx and out_last hold stable.
  - in_vec changes after the input handshake have no effect.
- Outputs are functions of registered state only. There is no combinational path from any input to any output.
- out_idx is zero-extended to W bits. Bits of in_vec at index >= 2^W cannot exist, given the constraint W >= clog2(N).
- in_valid while in_ready=0 is ignored; the producer must hold it.
- Priority select is a pure scan of pending. Expected RTL size: ~150–250 lines.

Test Plan:
- Single one-hot, N=10, MSB_FIRST=0, out_ready=1: in_vec=10'b0000000001 -> out_idx=0, out_last=1 one cycle after handshake; in_ready=1 again the following cycle.
- Multi-bit: in_vec=10'b1000100101, out_ready=1:
  - out_idx sequence 0,2,5,9 on consecutive cycles
  - out_last=1 only on index 9
  - busy high for 4 cycles
- Backpressure: same vector with out_ready toggled 0,1,0,0,1,...:
  - each index holds while out_ready=0
  - sequence stays 0,2,5,9
  - no index is duplicated or skipped
- MSB_FIRST=1, in_vec=10'b1111111111: out_idx sequence 9,8,...,0 over 10 cycles, out_last on index 0.
- Zero vector: in_vec=0 with in_valid=1 -> zero_drop pulses for 1 cycle, out_valid stays 0, in_ready stays 1.
- Reset mid-burst: in_vec=10'b0000011110, rst_n=0 after index 2 is emitted:
  - next cycle out_valid=0, busy=0, in_ready=1
  - a fresh vector 10'b0100000000 yields only out_idx=8, out_last=1
